// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// The optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro
// (see serial_adder_ctrl).
package serial_adder_pkg;

  // Sequencer states: waiting for operands, shifting bits, holding the result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_t;

  // Bit-counter width: enough to count 0..width-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder: the only arithmetic element of the serial adder.
// Purely combinational.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_c;
  assign o_cout = (i_c & w_p) | (i_a & i_b);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer.
// Operands are accepted on a valid/ready handshake, fed LSB-first into one
// full-adder cell (carry registered between cycles), and the parallel sum is
// held on Sum_DO/Cout_DO until the downstream handshake completes.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the Sub_DI port, which
// turns the operation into A - B (two's complement, Cout_DO=1 means no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             InValid_DI,
  output logic             InReady_DO,
  input  logic [WIDTH-1:0] A_DI,
  input  logic [WIDTH-1:0] B_DI,
  input  logic             Cin_DI,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub_DI,
`endif
  output logic             OutValid_DO,
  input  logic             OutReady_DI,
  output logic [WIDTH-1:0] Sum_DO,
  output logic             Cout_DO,
  output logic             Busy_DO
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_t            r_state_q, r_state_d;
  logic [WIDTH-1:0]  r_a_q, r_a_d;
  logic [WIDTH-1:0]  r_b_q, r_b_d;
  logic [WIDTH-1:0]  r_sum_q, r_sum_d;
  logic [CntW-1:0]   r_cnt_q, r_cnt_d;
  logic              r_carry_q, r_carry_d;
  logic              r_cout_q, r_cout_d;

  logic [WIDTH-1:0]  w_b_load;
  logic              w_cin_load;
  logic              w_fa_s;
  logic              w_fa_c;

  // Operand conditioning at the accepting edge: subtract is A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load   = Sub_DI ? ~B_DI : B_DI;
  assign w_cin_load = Sub_DI ? 1'b1 : Cin_DI;
`else
  assign w_b_load   = B_DI;
  assign w_cin_load = Cin_DI;
`endif

  fa_cell u_fa_cell (
    .i_a    (r_a_q[0]),
    .i_b    (r_b_q[0]),
    .i_c    (r_carry_q),
    .o_s    (w_fa_s),
    .o_cout (w_fa_c)
  );

  // Next-state and datapath updates for the three-state sequencer.
  always_comb begin
    r_state_d = r_state_q;
    r_a_d     = r_a_q;
    r_b_d     = r_b_q;
    r_sum_d   = r_sum_q;
    r_cnt_d   = r_cnt_q;
    r_carry_d = r_carry_q;
    r_cout_d  = r_cout_q;

    case (r_state_q)
      StIdle: begin
        if (InValid_DI) begin
          r_state_d = StCalc;
          r_a_d     = A_DI;
          r_b_d     = w_b_load;
          r_carry_d = w_cin_load;
          r_cnt_d   = '0;
          r_sum_d   = '0;
          r_cout_d  = 1'b0;
        end
      end

      StCalc: begin
        r_a_d     = r_a_q >> 1;
        r_b_d     = r_b_q >> 1;
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        r_sum_d   = (r_sum_q >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));
        r_carry_d = w_fa_c;
        r_cnt_d   = r_cnt_q + 1'b1;
        if (r_cnt_q == CntLast) begin
          r_state_d = StDone;
          r_cout_d  = w_fa_c;
        end
      end

      StDone: begin
        if (OutReady_DI) begin
          r_state_d = StIdle;
        end
      end

      default: begin
        r_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so an aborted
  // operation leaves no carry or partial sum behind.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_state_q <= StIdle;
      r_a_q     <= '0;
      r_b_q     <= '0;
      r_sum_q   <= '0;
      r_cnt_q   <= '0;
      r_carry_q <= 1'b0;
      r_cout_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_a_q     <= r_a_d;
      r_b_q     <= r_b_d;
      r_sum_q   <= r_sum_d;
      r_cnt_q   <= r_cnt_d;
      r_carry_q <= r_carry_d;
      r_cout_q  <= r_cout_d;
    end
  end

  assign InReady_DO  = (r_state_q == StIdle);
  assign OutValid_DO = (r_state_q == StDone);
  assign Busy_DO     = (r_state_q != StIdle);
  assign Sum_DO      = r_sum_q;
  assign Cout_DO     = r_cout_q;

endmodule
